// File: rtl/clk_ui_pkg.sv
// Shared encodings for the clock front-panel: display modes, adjust fields, blink masks.
package clk_ui_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'b00,
    MODE_ALARM     = 2'b01,
    MODE_STOPWATCH = 2'b10,
    MODE_ADJUST    = 2'b11
  } mode_t;

  localparam logic [1:0] FIELD_HI  = 2'd0;
  localparam logic [1:0] FIELD_MID = 2'd1;
  localparam logic [1:0] FIELD_LO  = 2'd2;

  localparam int BLINK_MS_DEF   = 500;
  localparam int TIMEOUT_MS_DEF = 10000;

  // Digit enables with the selected pair blanked; bit 0 is the lowest digit.
  function automatic logic [5:0] field_mask(input logic [1:0] field);
    case (field)
      FIELD_HI:  field_mask = 6'b001111;
      FIELD_MID: field_mask = 6'b110011;
      default:   field_mask = 6'b111100;
    endcase
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink phase generator: counts tick pulses and toggles the phase every BLINK_MS ticks.
// phase_next is the value the phase register takes at the next edge, so callers can register it alongside.
module blink_gen
  import clk_ui_pkg::*;
#(
  parameter int BLINK_MS = BLINK_MS_DEF,
  parameter int CNT_W    = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clr,
  output logic phase_next
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             phase;

  // Clear wins over a coincident tick so a fresh selection always starts a full on-phase.
  always_comb begin
    cnt_next   = cnt;
    phase_next = phase;
    if (clr) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (tick) begin
      if (cnt == CNT_W'(BLINK_MS - 1)) begin
        cnt_next   = '0;
        phase_next = ~phase;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/display_mode_ctrl.sv
// Front-panel sequencer: key pulses -> display mode, time/date select, adjust strobes, blink mask.
// Optional ADJ_TIMEOUT_EN macro: abandon ADJUST after TIMEOUT_MS idle ticks without committing.
module display_mode_ctrl
  import clk_ui_pkg::*;
#(
  parameter int BLINK_MS   = BLINK_MS_DEF,
  parameter int TIMEOUT_MS = TIMEOUT_MS_DEF,
  parameter int CNT_W      = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1ms,
  input  logic       key_mode,
  input  logic       key_dt,
  input  logic       key_sel,
  input  logic       key_inc,
  output logic [1:0] model,
  output logic       date_time_ch,
  output logic [1:0] adj_field,
  output logic       adj_load,
  output logic       adj_commit,
  output logic       adj_inc,
  output logic [5:0] blink_en
);

  mode_t      state;
  mode_t      state_nxt;
  logic       dt_nxt;
  logic [1:0] field_nxt;
  logic       load_nxt;
  logic       commit_nxt;
  logic       inc_nxt;
  logic [5:0] blink_nxt;
  logic       k_dt;
  logic       k_sel;
  logic       k_inc;
  logic       any_key;
  logic       timeout;
  logic       blink_clr;
  logic       phase_next;

  assign model = state;

  assign k_dt    = key_dt  & ~key_mode;
  assign k_sel   = key_sel & ~key_mode & ~key_dt;
  assign k_inc   = key_inc & ~key_mode & ~key_dt & ~key_sel;
  assign any_key = key_mode | key_dt | key_sel | key_inc;

`ifdef ADJ_TIMEOUT_EN
  logic [CNT_W-1:0] idle_cnt;
  // Any key, even one dropped by priority, counts as user activity.
  assign timeout = (state == MODE_ADJUST) && tick_1ms && !any_key &&
                   (idle_cnt == CNT_W'(TIMEOUT_MS - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    dt_nxt     = date_time_ch;
    field_nxt  = adj_field;
    load_nxt   = 1'b0;
    commit_nxt = 1'b0;
    inc_nxt    = 1'b0;
    if (key_mode) begin
      case (state)
        MODE_NORMAL: begin
          state_nxt = MODE_ALARM;
          field_nxt = FIELD_HI;
        end
        MODE_ALARM: state_nxt = MODE_STOPWATCH;
        MODE_STOPWATCH: begin
          state_nxt = MODE_ADJUST;
          field_nxt = FIELD_HI;
          load_nxt  = 1'b1;
        end
        default: begin
          state_nxt  = MODE_NORMAL;
          commit_nxt = 1'b1;
        end
      endcase
    end else if (timeout) begin
      state_nxt = MODE_NORMAL;
      field_nxt = FIELD_HI;
    end else if (k_dt) begin
      if (state == MODE_NORMAL) begin
        dt_nxt = ~date_time_ch;
      end else if (state == MODE_ADJUST) begin
        // Switching target mid-edit reloads from the newly selected live value.
        dt_nxt    = ~date_time_ch;
        field_nxt = FIELD_HI;
        load_nxt  = 1'b1;
      end
    end else if (k_sel) begin
      if (state == MODE_ADJUST) begin
        field_nxt = (adj_field == FIELD_LO) ? FIELD_HI : adj_field + 2'd1;
      end else if (state == MODE_ALARM) begin
        field_nxt = (adj_field == FIELD_HI) ? FIELD_MID : FIELD_HI;
      end
    end else if (k_inc) begin
      inc_nxt = (state == MODE_ADJUST) || (state == MODE_ALARM);
    end
  end

  assign blink_clr = (state_nxt != state) || k_sel;

  blink_gen #(
    .BLINK_MS (BLINK_MS),
    .CNT_W    (CNT_W)
  ) u_blink (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick_1ms),
    .clr        (blink_clr),
    .phase_next (phase_next)
  );

  always_comb begin
    blink_nxt = 6'b111111;
    if (((state_nxt == MODE_ADJUST) || (state_nxt == MODE_ALARM)) && !phase_next) begin
      blink_nxt = field_mask(field_nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= MODE_NORMAL;
      date_time_ch <= 1'b0;
      adj_field    <= FIELD_HI;
      adj_load     <= 1'b0;
      adj_commit   <= 1'b0;
      adj_inc      <= 1'b0;
      blink_en     <= 6'b111111;
`ifdef ADJ_TIMEOUT_EN
      idle_cnt     <= '0;
`endif
    end else begin
      state        <= state_nxt;
      date_time_ch <= dt_nxt;
      adj_field    <= field_nxt;
      adj_load     <= load_nxt;
      adj_commit   <= commit_nxt;
      adj_inc      <= inc_nxt;
      blink_en     <= blink_nxt;
`ifdef ADJ_TIMEOUT_EN
      if ((state_nxt != MODE_ADJUST) || any_key) begin
        idle_cnt <= '0;
      end else if (tick_1ms) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Self-checking bench for display_mode_ctrl: directed scenarios plus random key/tick traffic vs a reference model.
module tb_display_mode_ctrl;

  localparam int BLINK_MS   = 4;
  localparam int TIMEOUT_MS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1ms = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_dt = 1'b0;
  logic       key_sel = 1'b0;
  logic       key_inc = 1'b0;
  logic [1:0] model;
  logic       date_time_ch;
  logic [1:0] adj_field;
  logic       adj_load;
  logic       adj_commit;
  logic       adj_inc;
  logic [5:0] blink_en;

  display_mode_ctrl #(
    .BLINK_MS   (BLINK_MS),
    .TIMEOUT_MS (TIMEOUT_MS),
    .CNT_W      (14)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1ms     (tick_1ms),
    .key_mode     (key_mode),
    .key_dt       (key_dt),
    .key_sel      (key_sel),
    .key_inc      (key_inc),
    .model        (model),
    .date_time_ch (date_time_ch),
    .adj_field    (adj_field),
    .adj_load     (adj_load),
    .adj_commit   (adj_commit),
    .adj_inc      (adj_inc),
    .blink_en     (blink_en)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int n_load = 0;
  int n_commit = 0;
  int n_inc = 0;

  // Reference state: mode 0..3 as NORMAL, ALARM, STOPWATCH, ADJUST.
  int   m_mode, m_field, m_bcnt, m_idle;
  bit   m_dt, m_on;
  bit   e_load, e_commit, e_inc;
  logic [5:0] e_blink;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_field = 0; m_bcnt = 0; m_idle = 0;
    m_dt = 0; m_on = 1;
    e_load = 0; e_commit = 0; e_inc = 0; e_blink = 6'h3f;
  endtask

  task automatic model_step(input bit km, input bit kd, input bit ks, input bit ki, input bit tk);
    int   old_mode;
    bit   sel_hit;
    bit   tmo;
    logic [5:0] pair;
    old_mode = m_mode;
    sel_hit = 0;
    tmo = 0;
    e_load = 0; e_commit = 0; e_inc = 0;
`ifdef ADJ_TIMEOUT_EN
    if (m_mode == 3) begin
      if (km || kd || ks || ki) m_idle = 0;
      else if (tk) begin
        m_idle++;
        if (m_idle == TIMEOUT_MS) tmo = 1;
      end
    end
`endif
    if (km) begin
      if (m_mode == 0) m_field = 0;
      if (m_mode == 2) begin e_load = 1; m_field = 0; end
      if (m_mode == 3) e_commit = 1;
      m_mode = (m_mode + 1) % 4;
    end else if (tmo) begin
      m_mode = 0; m_field = 0;
    end else if (kd) begin
      if (m_mode == 0) m_dt = !m_dt;
      else if (m_mode == 3) begin m_dt = !m_dt; m_field = 0; e_load = 1; end
    end else if (ks) begin
      sel_hit = 1;
      if (m_mode == 3) m_field = (m_field + 1) % 3;
      else if (m_mode == 1) m_field = (m_field + 1) % 2;
    end else if (ki) begin
      e_inc = (m_mode == 3) || (m_mode == 1);
    end
    if (m_mode != 3) m_idle = 0;
    if (m_mode != old_mode || sel_hit) begin
      m_bcnt = 0; m_on = 1;
    end else if (tk) begin
      m_bcnt++;
      if (m_bcnt == BLINK_MS) begin m_bcnt = 0; m_on = !m_on; end
    end
    e_blink = 6'h3f;
    if ((m_mode == 1 || m_mode == 3) && !m_on) begin
      pair = 6'h3;
      pair = pair << (4 - 2 * m_field);
      e_blink = ~pair;
    end
  endtask

  task automatic cyc(input bit km, input bit kd, input bit ks, input bit ki, input bit tk);
    @(negedge clk);
    key_mode = km; key_dt = kd; key_sel = ks; key_inc = ki; tick_1ms = tk;
    model_step(km, kd, ks, ki, tk);
    @(posedge clk);
    #1;
    check_val("mode", 8'(model), 8'(m_mode));
    check_val("date_time", 8'(date_time_ch), 8'(m_dt));
    check_val("field", 8'(adj_field), 8'(m_field));
    check_val("strobes", {5'd0, adj_load, adj_commit, adj_inc}, {5'd0, e_load, e_commit, e_inc});
    check_val("blink", 8'(blink_en), 8'(e_blink));
    n_load += int'(adj_load);
    n_commit += int'(adj_commit);
    n_inc += int'(adj_inc);
    key_mode = 0; key_dt = 0; key_sel = 0; key_inc = 0; tick_1ms = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_mode"}, 8'(model), 8'd0);
    check_val({tag, "_dt"}, 8'(date_time_ch), 8'd0);
    check_val({tag, "_field"}, 8'(adj_field), 8'd0);
    check_val({tag, "_strobes"}, {5'd0, adj_load, adj_commit, adj_inc}, 8'd0);
    check_val({tag, "_blink"}, 8'(blink_en), 8'h3f);
  endtask

  logic [1:0] mode_seq [4];

  initial begin
    mode_seq[0] = 2'b01; mode_seq[1] = 2'b10; mode_seq[2] = 2'b11; mode_seq[3] = 2'b00;
    model_reset();
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Full mode cycle with exactly one load and one commit.
    n_load = 0; n_commit = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0);
      check_val("mode_step", 8'(model), 8'(mode_seq[i]));
      if (i == 2) check_val("load_on_adjust", 8'(adj_load), 8'd1);
      if (i == 3) check_val("commit_on_exit", 8'(adj_commit), 8'd1);
      repeat (9) cyc(0, 0, 0, 0, 0);
    end
    check_val("load_count", 8'(n_load), 8'd1);
    check_val("commit_count", 8'(n_commit), 8'd1);

    // Time/date toggle, then mode key shadows a simultaneous dt key.
    cyc(0, 1, 0, 0, 0);
    check_val("dt_toggle", 8'(date_time_ch), 8'd1);
    cyc(1, 1, 0, 0, 0);
    check_val("prio_mode", 8'(model), 8'd1);
    check_val("prio_dt_kept", 8'(date_time_ch), 8'd1);

    // Alarm field wraps after two pairs.
    cyc(0, 0, 1, 0, 0);
    check_val("alarm_sel1", 8'(adj_field), 8'd1);
    cyc(0, 0, 1, 0, 0);
    check_val("alarm_sel2", 8'(adj_field), 8'd0);

    cyc(1, 0, 0, 0, 0);
    n_inc = 0;
    repeat (3) cyc(0, 0, 0, 1, 0);
    check_val("sw_no_inc", 8'(n_inc), 8'd0);

    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check_val("adj_sel1", 8'(adj_field), 8'd1);
    cyc(0, 0, 1, 0, 0);
    check_val("adj_sel2", 8'(adj_field), 8'd2);
    cyc(0, 0, 1, 0, 0);
    check_val("adj_sel3", 8'(adj_field), 8'd0);

    // Blink on the middle pair, then reselect mid-off-phase.
    cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1);
    check_val("blink_still_on", 8'(blink_en), 8'h3f);
    cyc(0, 0, 0, 0, 1);
    check_val("blink_mid_off", 8'(blink_en), 8'h33);
    repeat (2) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    check_val("blink_sel_on", 8'(blink_en), 8'h3f);
    repeat (3) cyc(0, 0, 0, 0, 1);
    check_val("blink_lo_on", 8'(blink_en), 8'h3f);
    cyc(0, 0, 0, 0, 1);
    check_val("blink_lo_off", 8'(blink_en), 8'h3c);

    // Asynchronous reset in the middle of an edit on the low pair.
    check_val("pre_rst_field", 8'(adj_field), 8'd2);
    n_commit = 0;
    @(negedge clk);
    #4 rst = 1'b1;
    model_reset();
    #1 check_reset_outputs("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_val("rst_hold_commit", 8'(adj_commit), 8'd0);
    end
    @(negedge clk) rst = 1'b0;
    repeat (4) cyc(0, 0, 0, 0, 0);
    check_val("post_rst_commit", 8'(n_commit), 8'd0);

`ifdef ADJ_TIMEOUT_EN
    repeat (3) cyc(1, 0, 0, 0, 0);
    n_commit = 0;
    repeat (7) cyc(0, 0, 0, 0, 1);
    check_val("tmo_before", 8'(model), 8'd3);
    cyc(0, 0, 0, 0, 1);
    check_val("tmo_exit", 8'(model), 8'd0);
    check_val("tmo_no_commit", 8'(n_commit), 8'd0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    repeat (6) cyc(0, 0, 0, 0, 1);
    check_val("tmo_tick12", 8'(model), 8'd3);
    cyc(0, 0, 0, 0, 1);
    check_val("tmo_tick13", 8'(model), 8'd3);
    cyc(0, 0, 0, 0, 1);
    check_val("tmo_tick14", 8'(model), 8'd0);
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
